// File: rtl/blend_channel_sequencer.sv
// rtl/blend_channel_sequencer.sv - sequences R/G/B of one pixel through a shared 6-bit blend unit
module blend_channel_sequencer #(
    parameter bit BYPASS_FAST = 1'b1,
    parameter bit IDLE_ZERO   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [8:0]  s_op,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
    input  logic [17:0] s_c,
    output logic [8:0]  blend_op,
    output logic [5:0]  blend_a,
    output logic [5:0]  blend_b,
    output logic [5:0]  blend_c,
    input  logic [5:0]  blend_o,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [17:0] m_rgb
);

    typedef enum logic [2:0] {IDLE, CH_R, CH_G, CH_B, OUT} state_t;

    state_t      state, next_state;
    logic [8:0]  op_q;
    // R is fed straight from s_* on the accept edge, so only G/B need holding
    logic [11:0] a_gb, b_gb, c_gb;
    logic        accept, bypass, blend_load;
    logic [8:0]  nxt_op;
    logic [5:0]  nxt_a, nxt_b, nxt_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        bypass     = BYPASS_FAST && s_op[8];
        case (state)
            IDLE: begin
                s_ready = reset_n;
                if (s_valid) next_state = bypass ? OUT : CH_R;
            end
            CH_R: next_state = CH_G;
            CH_G: next_state = CH_B;
            CH_B: next_state = OUT;
            OUT: begin
                s_ready = reset_n && m_ready;
                if (m_ready) begin
                    if (s_valid) next_state = bypass ? OUT : CH_R;
                    else         next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        accept = s_valid && s_ready;
    end

    always_comb begin
        blend_load = 1'b1;
        nxt_op     = 9'd0;
        nxt_a      = 6'd0;
        nxt_b      = 6'd0;
        nxt_c      = 6'd0;
        case (next_state)
            CH_R: begin
                nxt_op = s_op;
                nxt_a  = s_a[17:12];
                nxt_b  = s_b[17:12];
                nxt_c  = s_c[17:12];
            end
            CH_G: begin
                nxt_op = op_q;
                nxt_a  = a_gb[11:6];
                nxt_b  = b_gb[11:6];
                nxt_c  = c_gb[11:6];
            end
            CH_B: begin
                nxt_op = op_q;
                nxt_a  = a_gb[5:0];
                nxt_b  = b_gb[5:0];
                nxt_c  = c_gb[5:0];
            end
            default: blend_load = IDLE_ZERO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= 9'd0;
            a_gb     <= 12'd0;
            b_gb     <= 12'd0;
            c_gb     <= 12'd0;
            blend_op <= 9'd0;
            blend_a  <= 6'd0;
            blend_b  <= 6'd0;
            blend_c  <= 6'd0;
            m_rgb    <= 18'd0;
        end else begin
            if (accept) begin
                op_q <= s_op;
                a_gb <= s_a[11:0];
                b_gb <= s_b[11:0];
                c_gb <= s_c[11:0];
            end
            if (blend_load) begin
                blend_op <= nxt_op;
                blend_a  <= nxt_a;
                blend_b  <= nxt_b;
                blend_c  <= nxt_c;
            end
            // blend_o is combinational from blend_*, so it is consumed at the edge leaving each channel
            case (state)
                CH_R:    m_rgb[17:12] <= blend_o;
                CH_G:    m_rgb[11:6]  <= blend_o;
                CH_B:    m_rgb[5:0]   <= blend_o;
                default: ;
            endcase
            if (accept && bypass) m_rgb <= s_a;
        end
    end

    assign m_valid = (state == OUT);

endmodule

// File: tb/tb_blend_channel_sequencer.sv
// tb/tb_blend_channel_sequencer.sv - directed and random checks of blend_channel_sequencer
module tb_blend_channel_sequencer;

    logic        clk;
    logic        reset_n;
    logic        s_valid;
    logic        s_ready;
    logic [8:0]  s_op;
    logic [17:0] s_a, s_b, s_c;
    logic [8:0]  blend_op;
    logic [5:0]  blend_a, blend_b, blend_c, blend_o;
    logic        m_valid;
    logic        m_ready;
    logic [17:0] m_rgb;

    int checks = 0;
    int errors = 0;

    blend_channel_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_op     (s_op),
        .s_a      (s_a),
        .s_b      (s_b),
        .s_c      (s_c),
        .blend_op (blend_op),
        .blend_a  (blend_a),
        .blend_b  (blend_b),
        .blend_c  (blend_c),
        .blend_o  (blend_o),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_rgb    (m_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in blend unit: A doubled with 6-bit wrap, weighted sum, >>3, wrapped to 6 bits
    function automatic logic [5:0] unit_f(input logic [8:0] op, input logic [5:0] a, input logic [5:0] b,
                                          input logic [5:0] c);
        logic [9:0] ax, bx, cx, wa, wb, wc, sum;
        ax  = {4'd0, a[4:0], 1'b0};
        bx  = {4'd0, b};
        cx  = {4'd0, c};
        wa  = {7'd0, op[7:5]};
        wb  = op[4] ? 10'd1 : {8'd0, op[3:2]};
        wc  = op[4] ? 10'd1 : {8'd0, op[1:0]};
        sum = ax * wa + bx * wb + cx * wc;
        return sum[8:3];
    endfunction

    function automatic logic [17:0] ref_pix(input logic [8:0] op, input logic [17:0] a, input logic [17:0] b,
                                            input logic [17:0] c);
        if (op[8]) return a;
        return {unit_f(op, a[17:12], b[17:12], c[17:12]),
                unit_f(op, a[11:6],  b[11:6],  c[11:6]),
                unit_f(op, a[5:0],   b[5:0],   c[5:0])};
    endfunction

    assign blend_o = unit_f(blend_op, blend_a, blend_b, blend_c);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at the negedge where a normal pixel is offered; ends at the negedge in OUT
    task automatic chan_seq(input string tag, input logic [5:0] e0, input logic [5:0] e1, input logic [5:0] e2);
        @(negedge clk);
        s_valid = 1'b0;
        check({tag, "_ch_r"}, blend_a, e0);
        check({tag, "_mv_r"}, m_valid, 0);
        @(negedge clk);
        check({tag, "_ch_g"}, blend_a, e1);
        @(negedge clk);
        check({tag, "_ch_b"}, blend_a, e2);
        @(negedge clk);
        check({tag, "_valid"}, m_valid, 1);
    endtask

    initial begin
        logic [17:0] expq[$];
        logic        have;
        int          sent, rcvd, cyc;
        logic [17:0] pa, pb, pc;
        logic [8:0]  pop;

        reset_n = 1'b0;
        s_valid = 1'b0;
        s_op    = 9'd0;
        s_a     = 18'd0;
        s_b     = 18'd0;
        s_c     = 18'd0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_rgb", m_rgb, 0);
        check("rst_blend_a", blend_a, 0);
        check("rst_blend_op", blend_op, 0);
        reset_n = 1'b1;
        #1;
        check("idle_s_ready", s_ready, 1);

        // single pixel, A weight 7 on full white
        s_valid = 1'b1; s_op = 9'h0E0; s_a = 18'h3FFFF; s_b = 18'd0; s_c = 18'd0;
        chan_seq("t1", 6'd63, 6'd63, 6'd63);
        check("t1_rgb", m_rgb, 18'h36DB6);
        check("t1_out_zero", blend_a, 0);
        m_ready = 1'b1;
        @(negedge clk);
        check("t1_drop", m_valid, 0);

        // channel ordering
        s_valid = 1'b1; s_op = 9'h010; s_a = 18'h01083;
        chan_seq("t2", 6'd1, 6'd2, 6'd3);
        check("t2_rgb", m_rgb, 18'h0);
        @(negedge clk);

        // bypass, back to back
        s_valid = 1'b1; s_op = 9'h100; s_a = 18'h2AA55;
        @(negedge clk);
        check("t3_valid", m_valid, 1);
        check("t3_rgb", m_rgb, 18'h2AA55);
        check("t3_blend_a", blend_a, 0);
        check("t3_blend_op", blend_op, 0);
        s_a = 18'h15AAA;
        @(negedge clk);
        check("t3_valid2", m_valid, 1);
        check("t3_rgb2", m_rgb, 18'h15AAA);
        s_valid = 1'b0;
        @(negedge clk);
        check("t3_drop", m_valid, 0);

        // backpressure
        m_ready = 1'b0;
        s_valid = 1'b1; s_op = 9'h0E0; s_a = 18'h0A51E;
        chan_seq("t4", 6'd10, 6'd20, 6'd30);
        check("t4_rgb", m_rgb, 18'h118F4);
        s_valid = 1'b1; s_a = 18'h3FFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_ready", s_ready, 0);
            check("t4_hold_rgb", m_rgb, 18'h118F4);
        end
        m_ready = 1'b1;
        #1;
        check("t4_release_ready", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("t4_new_mv", m_valid, 0);
        check("t4_new_ch_r", blend_a, 63);
        repeat (3) @(negedge clk);
        check("t4_new_valid", m_valid, 1);
        check("t4_new_rgb", m_rgb, 18'h36DB6);
        m_ready = 1'b1;
        @(negedge clk);

        // async reset during CH_G
        s_valid = 1'b1; s_op = 9'h0E0; s_a = 18'h3FFFF;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        check("t5_in_ch_g", blend_a, 63);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_mv", m_valid, 0);
        check("t5_rst_blend_a", blend_a, 0);
        check("t5_rst_blend_op", blend_op, 0);
        check("t5_rst_s_ready", s_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        s_valid = 1'b1; s_op = 9'h0E0; s_a = 18'h01083;
        chan_seq("t5", 6'd1, 6'd2, 6'd3);
        check("t5_rgb", m_rgb, 18'h010C5);
        @(negedge clk);

        // random stream with random backpressure
        have = 1'b0;
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        pa = 18'd0; pb = 18'd0; pc = 18'd0; pop = 9'd0;
        while ((sent < 1000 || rcvd < 1000) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (!have && sent < 1000) begin
                pop    = 9'($urandom);
                pop[8] = ($urandom_range(0, 3) == 0);
                pa     = 18'($urandom);
                pb     = 18'($urandom);
                pc     = 18'($urandom);
                have   = 1'b1;
            end
            s_op    = pop;
            s_a     = pa;
            s_b     = pb;
            s_c     = pc;
            s_valid = have && ($urandom_range(0, 7) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (m_valid && m_ready) begin
                if (expq.size() == 0) check("rand_extra", 1, 0);
                else                  check("rand_pix", m_rgb, expq.pop_front());
                rcvd++;
            end
            if (s_valid && s_ready) begin
                expq.push_back(ref_pix(pop, pa, pb, pc));
                sent++;
                have = 1'b0;
            end
        end
        s_valid = 1'b0;
        check("rand_count", rcvd, 1000);
        check("rand_left", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
